// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: shares the LSU data-memory port between loads and an in-order forwarding store buffer
module lsu_mem_arbiter #(
  parameter int SB_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_valid,
  input  logic [31:0]               ld_addr,
  input  logic                      ld_byte,
  input  logic [31:0]               ld_pc,
  output logic                      ld_ready,
  output logic                      ld_done,
  output logic [31:0]               ld_data,
  output logic [31:0]               ld_pc_out,
  output logic                      ld_from_sb,
  input  logic                      st_valid,
  input  logic [31:0]               st_addr,
  input  logic [31:0]               st_data,
  input  logic                      st_byte,
  output logic                      st_ready,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  output logic                      mem_byte,
  input  logic                      mem_done,
  input  logic [31:0]               mem_rdata,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_empty
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT} state_t;
  state_t state, state_d;
  logic [31:0] sb_addr [SB_DEPTH];
  logic [31:0] sb_data [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_byte;
  logic [PW-1:0] head, tail, idx;
  logic [SW-1:0] starve;
  logic [31:0] lat_pc, hit_data, fwd_data;
  logic [1:0] hit_lo;
  logic hit, hit_byte, fwd, conflict, sb_full, idle, fwd_go, st_go, ld_go, push, pop, done_evt;

  function automatic logic [31:0] sext_byte(input logic [31:0] w, input logic [1:0] a);
    logic [7:0] b;
    b = w[{a, 3'b000} +: 8];
    return {{24{b[7]}}, b};
  endfunction

  assign sb_full = sb_count == (PW+1)'(SB_DEPTH);
  assign sb_empty = sb_count == '0;
  assign st_ready = !sb_full;
  assign push = st_valid && st_ready;
  assign pop = state == ST_WAIT && mem_done;
  assign done_evt = state != IDLE && mem_done;
  assign fwd = hit && (ld_byte ? (!hit_byte || hit_lo == ld_addr[1:0]) : (!hit_byte && ld_addr[1:0] == 2'b00));
  assign conflict = hit && !fwd;
  assign fwd_data = ld_byte ? sext_byte(hit_data, hit_byte ? 2'b00 : ld_addr[1:0]) : hit_data;

  always_comb begin
    hit = 1'b0;
    hit_lo = '0;
    hit_data = '0;
    hit_byte = 1'b0;
    idx = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PW'(i);
      if (i < int'(sb_count) && sb_addr[idx][31:2] == ld_addr[31:2]) begin
        hit = 1'b1;
        hit_lo = sb_addr[idx][1:0];
        hit_data = sb_data[idx];
        hit_byte = sb_byte[idx];
      end
    end
  end

  always_comb begin
    idle = state == IDLE && !rst;
    fwd_go = idle && ld_valid && fwd;
    st_go = idle && !fwd_go && !sb_empty && (sb_full || conflict || starve == SW'(STARVE_MAX) || !ld_valid);
    ld_go = idle && ld_valid && !fwd_go && !st_go;
    ld_ready = fwd_go || ld_go;
    state_d = st_go ? ST_WAIT : ld_go ? LD_WAIT : done_evt ? IDLE : state;
  end

  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= st_addr;
      sb_data[tail] <= st_data;
      sb_byte[tail] <= st_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      sb_count <= '0;
      starve <= '0;
      lat_pc <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_byte <= 1'b0;
      ld_done <= 1'b0;
      ld_data <= '0;
      ld_pc_out <= '0;
      ld_from_sb <= 1'b0;
    end else begin
      head <= pop ? head + PW'(1) : head;
      tail <= push ? tail + PW'(1) : tail;
      sb_count <= sb_count + (PW+1)'(push) - (PW+1)'(pop);
      starve <= st_go ? '0 : (ld_go && !sb_empty && starve != SW'(STARVE_MAX)) ? starve + SW'(1) : starve;
      ld_done <= fwd_go || (state == LD_WAIT && mem_done);
      if (fwd_go) begin
        ld_data <= fwd_data;
        ld_pc_out <= ld_pc;
        ld_from_sb <= 1'b1;
      end else if (state == LD_WAIT && mem_done) begin
        ld_data <= mem_byte ? sext_byte(mem_rdata, mem_addr[1:0]) : mem_rdata;
        ld_pc_out <= lat_pc;
        ld_from_sb <= 1'b0;
      end
      if (st_go) begin
        mem_req <= 1'b1;
        mem_we <= 1'b1;
        mem_addr <= sb_addr[head];
        mem_wdata <= sb_data[head];
        mem_byte <= sb_byte[head];
      end else if (ld_go) begin
        mem_req <= 1'b1;
        mem_we <= 1'b0;
        mem_addr <= ld_addr;
        mem_wdata <= '0;
        mem_byte <= ld_byte;
        lat_pc <= ld_pc;
      end else if (done_evt) begin
        mem_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: directed scoreboard bench for the load/store memory-port arbiter
module tb_lsu_mem_arbiter;
  typedef struct packed {logic [31:0] pc; logic [31:0] data; logic fsb;} exp_t;
  logic clk = 1'b0, rst = 1'b0;
  logic ld_valid = 1'b0, ld_byte = 1'b0, st_valid = 1'b0, st_byte = 1'b0;
  logic [31:0] ld_addr = '0, ld_pc = '0, st_addr = '0, st_data = '0;
  logic ld_ready, ld_done, ld_from_sb, st_ready, mem_req, mem_we, mem_byte, mem_done, sb_empty;
  logic [31:0] ld_data, ld_pc_out, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [2:0] sb_count;
  logic rsp_done = 1'b0, man_done = 1'b0, auto_mem = 1'b1, req_q = 1'b0;
  logic [31:0] mem [1024];
  int lat = 4, cyc = 0, last_done_cyc = -10, checks = 0, errors = 0;
  exp_t exp_q [$];
  logic [32:0] glog [$];

  assign mem_done = rsp_done | man_done;
  always #5 clk = ~clk;

  lsu_mem_arbiter #(.SB_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byte(ld_byte), .ld_pc(ld_pc),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_data(ld_data), .ld_pc_out(ld_pc_out), .ld_from_sb(ld_from_sb),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte), .st_ready(st_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte(mem_byte),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .sb_count(sb_count), .sb_empty(sb_empty)
  );

  initial begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = (32'(i) * 32'h0001_0001) ^ 32'hA500_0000;
    mem['h040] = 32'hDEAD_BEEF;
    mem['h0C0] = 32'h0000_0000;
    mem['h180] = 32'hCAFE_0001;
    mem['h181] = 32'h0000_F000;
    forever begin
      @(negedge clk);
      rsp_done = 1'b0;
      if (!mem_req || rst) cnt = 0;
      else if (auto_mem) begin
        cnt++;
        if (cnt == lat) begin
          rsp_done = 1'b1;
          last_done_cyc = cyc;
          if (!mem_we) mem_rdata = mem[mem_addr[11:2]];
          else if (mem_byte) mem[mem_addr[11:2]][{mem_addr[1:0], 3'b000} +: 8] = mem_wdata[7:0];
          else mem[mem_addr[11:2]] = mem_wdata;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (mem_req && !req_q) glog.push_back({mem_we, mem_addr});
    req_q = mem_req;
    if (ld_done) begin
      if (exp_q.size() == 0) chk("unexpected_ld_done", 32'(ld_done), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("ld_data", ld_data, e.data);
        chk("ld_pc_out", ld_pc_out, e.pc);
        chk("ld_from_sb", 32'(ld_from_sb), 32'(e.fsb));
        if (!e.fsb) chk("ld_mem_latency", 32'(cyc), 32'(last_done_cyc + 1));
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
    mon();
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    #1;
    while (!ld_ready && n < 100) begin
      adv();
      n++;
    end
    chk(tag, 32'(ld_ready), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mem_req || !sb_empty) && n < 300) begin
      adv();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_grant(input string tag, input logic we, input logic [31:0] addr);
    logic [32:0] g;
    if (glog.size() == 0) chk({tag, "_missing"}, 32'(glog.size()), 32'd1);
    else begin
      g = glog.pop_front();
      chk({tag, "_we"}, 32'(g[32]), 32'(we));
      chk({tag, "_addr"}, g[31:0], addr);
    end
  endtask

  initial begin
    int n, k, n_sb;
    logic acc, st_seen, sent, fin;
    rst = 1'b1;
    adv();
    adv();
    rst = 1'b0;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    chk("rst_sb_count", 32'(sb_count), 32'd0);
    chk("rst_sb_empty", 32'(sb_empty), 32'd1);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_ld_data", ld_data, 32'd0);
    lat = 4;
    ld_valid = 1'b1;
    ld_addr = 32'h100;
    ld_pc = 32'h1000;
    ld_byte = 1'b0;
    exp_q.push_back({32'h1000, 32'hDEAD_BEEF, 1'b0});
    #1;
    chk("t1_ready", 32'(ld_ready), 32'd1);
    adv();
    ld_valid = 1'b0;
    chk("t1_mem_req", 32'(mem_req), 32'd1);
    chk("t1_mem_we", 32'(mem_we), 32'd0);
    chk("t1_mem_addr", mem_addr, 32'h100);
    drain("t1_drain");
    glog.delete();
    st_valid = 1'b1;
    st_addr = 32'h200;
    st_data = 32'h1122_3344;
    st_byte = 1'b0;
    adv();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_byte = 1'b1;
    ld_addr = 32'h202;
    ld_pc = 32'h2000;
    exp_q.push_back({32'h2000, 32'h0000_0022, 1'b1});
    #1;
    chk("t2_ready", 32'(ld_ready), 32'd1);
    chk("t2_no_req0", 32'(mem_req), 32'd0);
    adv();
    ld_valid = 1'b0;
    chk("t2_done", 32'(ld_done), 32'd1);
    chk("t2_no_req1", 32'(mem_req), 32'd0);
    drain("t2_drain");
    chk_grant("t2_store", 1'b1, 32'h200);
    chk("t2_mem_word", mem['h080], 32'h1122_3344);
    st_valid = 1'b1;
    st_addr = 32'h300;
    st_data = 32'h0000_0080;
    st_byte = 1'b1;
    adv();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_byte = 1'b0;
    ld_addr = 32'h300;
    ld_pc = 32'h3000;
    exp_q.push_back({32'h3000, 32'h0000_0080, 1'b0});
    #1;
    chk("t3_stall", 32'(ld_ready), 32'd0);
    adv();
    chk("t3_st_req", 32'(mem_req), 32'd1);
    chk("t3_st_we", 32'(mem_we), 32'd1);
    chk("t3_st_byte", 32'(mem_byte), 32'd1);
    chk("t3_st_addr", mem_addr, 32'h300);
    chk("t3_stall2", 32'(ld_ready), 32'd0);
    wait_ready("t3_ready");
    chk("t3_sb_empty", 32'(sb_count), 32'd0);
    adv();
    ld_valid = 1'b0;
    drain("t3_drain");
    glog.delete();
    lat = 8;
    ld_valid = 1'b1;
    ld_byte = 1'b0;
    ld_addr = 32'h600;
    ld_pc = 32'h4000;
    exp_q.push_back({32'h4000, 32'hCAFE_0001, 1'b0});
    wait_ready("t4_l0_ready");
    adv();
    ld_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      st_valid = 1'b1;
      st_addr = 32'h500 + 32'(4 * s);
      st_data = 32'hA000_0001 + 32'(s);
      st_byte = 1'b0;
      adv();
    end
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_byte = 1'b1;
    ld_addr = 32'h605;
    ld_pc = 32'h4004;
    exp_q.push_back({32'h4004, 32'hFFFF_FFF0, 1'b0});
    chk("t4_full_count", 32'(sb_count), 32'd4);
    chk("t4_full_st_ready", 32'(st_ready), 32'd0);
    n = 0;
    while (sb_count != 3'd3 && n < 60) begin
      adv();
      n++;
    end
    chk("t4_pop_count", 32'(sb_count), 32'd3);
    chk("t4_st_ready_back", 32'(st_ready), 32'd1);
    wait_ready("t4_l1_ready");
    adv();
    ld_valid = 1'b0;
    drain("t4_drain");
    chk_grant("t4_g0", 1'b0, 32'h600);
    chk_grant("t4_g1", 1'b1, 32'h500);
    chk_grant("t4_g2", 1'b0, 32'h605);
    chk_grant("t4_g3", 1'b1, 32'h504);
    chk_grant("t4_g4", 1'b1, 32'h508);
    chk_grant("t4_g5", 1'b1, 32'h50C);
    lat = 1;
    k = 0;
    n_sb = 0;
    st_seen = 1'b0;
    sent = 1'b0;
    fin = 1'b0;
    ld_valid = 1'b1;
    ld_byte = 1'b0;
    ld_addr = 32'h800;
    ld_pc = 32'h5000;
    for (int c = 0; c < 200 && !fin; c++) begin
      #1;
      if (mem_req && mem_we && !st_seen) begin
        st_seen = 1'b1;
        chk("t5_starve_grants", 32'(n_sb), 32'd8);
        chk("t5_store_addr", mem_addr, 32'h700);
      end
      acc = ld_ready;
      if (acc && !st_seen && !sb_empty) n_sb++;
      if (acc) exp_q.push_back({ld_pc, mem[ld_addr[11:2]], 1'b0});
      adv();
      st_valid = 1'b0;
      if (acc && !sent) begin
        st_valid = 1'b1;
        st_addr = 32'h700;
        st_data = 32'h7777_0000;
        st_byte = 1'b0;
        sent = 1'b1;
      end
      if (acc && st_seen) begin
        ld_valid = 1'b0;
        fin = 1'b1;
      end else if (acc) begin
        k++;
        ld_addr = 32'h800 + 32'(4 * k);
        ld_pc = 32'h5000 + 32'(4 * k);
      end
    end
    st_valid = 1'b0;
    ld_valid = 1'b0;
    chk("t5_finished", 32'(fin), 32'd1);
    drain("t5_drain");
    auto_mem = 1'b0;
    st_valid = 1'b1;
    st_addr = 32'h900;
    st_data = 32'h1234_5678;
    st_byte = 1'b0;
    adv();
    st_valid = 1'b0;
    n = 0;
    while (!(mem_req && mem_we) && n < 20) begin
      adv();
      n++;
    end
    chk("t6_st_wait", 32'(mem_req && mem_we), 32'd1);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    man_done = 1'b1;
    adv();
    man_done = 1'b0;
    adv();
    chk("t6_mem_req", 32'(mem_req), 32'd0);
    chk("t6_mem_we", 32'(mem_we), 32'd0);
    chk("t6_mem_addr", mem_addr, 32'd0);
    chk("t6_mem_wdata", mem_wdata, 32'd0);
    chk("t6_mem_byte", 32'(mem_byte), 32'd0);
    chk("t6_ld_done", 32'(ld_done), 32'd0);
    chk("t6_ld_data", ld_data, 32'd0);
    chk("t6_ld_pc_out", ld_pc_out, 32'd0);
    chk("t6_ld_from_sb", 32'(ld_from_sb), 32'd0);
    chk("t6_sb_count", 32'(sb_count), 32'd0);
    chk("t6_sb_empty", 32'(sb_empty), 32'd1);
    adv();
    chk("t6_no_pop", 32'(sb_count), 32'd0);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Sequences the LSU's single data-memory port between loads (issued from the LSQ through the LSU) and committed stores.
- Holds committed stores in a small in-order store buffer (SB) and drains them to memory when the port is free.
- Forwards store data to younger loads that hit the SB.
- Sits between the LSU outputs and the data memory; one memory transaction is outstanding at a time.

Parameters:
SB_DEPTH, 4, store buffer entries (power of 2, >=2)
STARVE_MAX, 8, consecutive load grants allowed while SB non-empty before a store is forced

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
ld_valid  in  1  load request pending; ld_* held stable until ld_ready
ld_addr  in  32  load byte address
ld_byte  in  1  1=LB (sign-extended byte), 0=LW
ld_pc  in  32  load instruction PC
ld_ready  out  1  load accepted this cycle (combinational)
ld_done  out  1  one-cycle pulse, load result valid
ld_data  out  32  load result
ld_pc_out  out  32  PC of completed load
ld_from_sb  out  1  result was forwarded from SB (valid with ld_done)
st_valid  in  1  committed store enqueue request
st_addr  in  32  store byte address
st_data  in  32  store data (SB uses [7:0])
st_byte  in  1  1=SB, 0=SW
st_ready  out  1  SB not full (combinational from count)
mem_req  out  1  memory request, held until mem_done
mem_we  out  1  1=write
mem_addr  out  32  byte address
mem_wdata  out  32  write data
mem_byte  out  1  byte-sized access
mem_done  in  1  one-cycle completion pulse; mem_rdata valid for reads
mem_rdata  in  32  word containing mem_addr
sb_count  out  $clog2(SB_DEPTH)+1  occupied SB entries
sb_empty  out  1  sb_count==0

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; SB pointers, count and starve counter go to 0.
  - All outputs go to 0.
  - An in-flight memory transaction is abandoned; mem_done arriving in IDLE is ignored.
- Store buffer:
  - Circular FIFO; enqueue on st_valid&&st_ready, pop on store mem_done.
  - Simultaneous enqueue and pop leaves the count unchanged; pointers wrap modulo SB_DEPTH.
  - An entry enqueued in cycle N is visible to forwarding from cycle N+1.
- Forward check (combinational, all valid SB entries, youngest match wins; match = equal addr[31:2]):
  - LW, aligned, youngest match is SW: forward st_data.
  - LB, youngest match is SW: forward the byte at ld_addr[1:0], sign-extended.
  - LB, youngest match is SB with equal full address: forward data[7:0], sign-extended.
  - Any other match (LW hitting an SB entry, LB hitting an SB entry at a different byte, misaligned LW): conflict. The load is not accepted and stores drain until no match remains.
  - No match: miss.
- FSM states: IDLE, LD_WAIT, ST_WAIT.
- IDLE, evaluated in this priority order:
  1. ld_valid && forward hit: ld_ready=1. Next cycle ld_done=1, ld_from_sb=1, ld_data/ld_pc_out loaded. No memory access; stay IDLE. Forwarding does not touch the starve counter.
  2. SB full, or conflict, or (SB non-empty && starve==STARVE_MAX), or (!ld_valid && SB non-empty): issue the SB head. mem_req=1, mem_we=1, addr/data/byte from head; go to ST_WAIT; starve counter cleared.
  3. ld_valid && miss: ld_ready=1, mem_req=1, mem_we=0, mem_addr=ld_addr, mem_byte=ld_byte; latch pc/addr/byte; go to LD_WAIT. Starve counter increments (saturating) if SB non-empty.
- mem_req and mem_* are registered outputs, first high the cycle after the grant decision.
- mem_req and mem_* stay constant until mem_done.
- LD_WAIT: on mem_done, return to IDLE. The next cycle pulses ld_done with ld_from_sb=0.
  - LW: ld_data=mem_rdata.
  - LB: ld_data=sign-extended mem_rdata byte at addr[1:0].
- ST_WAIT: on mem_done, pop the head and return to IDLE.
- Latency:
  - Forwarded load: ld_done 1 cycle after ld_ready.
  - Memory load: ld_done 1 cycle after mem_done.
  - Minimum back-to-back gap: 1 IDLE cycle between transactions.
- ld_ready and ld_done are never high in the same cycle for the same load.
- ld_done is 0 in all other cycles.

Test Plan:
- Empty SB, LW 0x100, mem_done 3 cycles after mem_req with rdata=0xDEADBEEF: mem_we=0, mem_addr=0x100; ld_done 1 cycle after mem_done; ld_data=0xDEADBEEF, ld_from_sb=0.
- Enqueue SW 0x200=0x11223344, next cycle LB 0x202: ld_ready the same cycle, ld_done next cycle; ld_data=0x00000022, ld_from_sb=1; no mem_req.
- Enqueue SB 0x300=0x80, then LW 0x300: load stalls (ld_ready=0); store issued with mem_byte=1; after mem_done the SB is empty; the load then issues to memory.
- Fill SB with 4 stores (st_ready drops at count=4), ld_valid held on a non-matching address: the first grant is a store; count decrements on mem_done; st_ready reasserts.
- SB holding 1 non-matching store, continuous miss loads: exactly STARVE_MAX=8 load grants, then the store is granted; starve counter reset.
- Assert rst during ST_WAIT, then mem_done: all outputs 0, sb_count=0, no pop and no ld_done after reset.
